param_report_arbiter: RTL and testbench
=======================================

Name: param_report_arbiter

Overview:
Shares one report/log channel among NUM_REQ parameter-reporting instances. Typical requesters are the checker instances bound into each dut, each publishing its NAME id and X/Y/Z values. The block grants requesters round-robin, latches the winner's values, and serialises them as three beats (X, Y, Z) on a valid/ready output. It pulses an ack back to the winner when its report completes.

Parameters:
NUM_REQ, 4, number of requesters (1..16); ID_W = max(1, $clog2(NUM_REQ)) is a derived localparam.
VAL_W, 32, width of each X/Y/Z value and of out_data.
Z_DEFAULT, 4, value sent in the Z beat when the requester marks Z as not supplied.

Ports:
clk  in  1  clock; all logic on its rising edge.
rst_n  in  1  synchronous reset, active low.
req  in  NUM_REQ  per-requester report request; held until ack.
x_val  in  NUM_REQ*VAL_W  packed X values; requester i uses bits [i*VAL_W +: VAL_W].
y_val  in  NUM_REQ*VAL_W  packed Y values.
z_val  in  NUM_REQ*VAL_W  packed Z values.
z_sup  in  NUM_REQ  1 = z_val valid; 0 = send Z_DEFAULT.
ack  out  NUM_REQ  one-hot pulse on the final-beat handshake.
out_valid  out  1  beat valid.
out_ready  in  1  downstream accept.
out_data  out  VAL_W  beat value.
out_field  out  2  beat field: 0=X, 1=Y, 2=Z.
out_id  out  ID_W  index of the granted requester.
out_last  out  1  high on the Z beat.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (rst_n low at a clock edge): FSM=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_field=0, out_id=0, out_last=0, busy=0, ack=0.
- Reset mid-report: the report is dropped with no ack. Pending requests are re-arbitrated from rr_ptr=0.
- FSM states: IDLE, SEND_X, SEND_Y, SEND_Z.
- IDLE -> SEND_X: when any req bit is high.
  - Winner = first set bit searching rr_ptr, rr_ptr+1, ... with wrap at NUM_REQ.
  - On that edge, latch x, y, and (z_sup ? z_val : Z_DEFAULT) of the winner, and set out_id=winner.
  - Set rr_ptr = (winner+1) mod NUM_REQ.
- SEND_X -> SEND_Y -> SEND_Z: each advance on out_valid & out_ready.
- SEND_Z -> IDLE: on handshake. IDLE always lasts at least one cycle.
- Latency: the grant edge follows the first IDLE cycle seeing req, and out_valid rises the following cycle. With out_ready held high, one report takes 4 cycles (IDLE + 3 beats).
- Output rules:
  - out_valid=1 in all SEND_* states.
  - out_data, out_field, out_id and out_last must be stable while out_valid & !out_ready.
- ack[i] = out_valid & out_ready & out_last & (out_id==i), combinational. Exactly one bit at most is high, for one cycle.
- Requester contract:
  - Drop req on the edge where ack is seen.
  - Input values may change after grant; the latched copies are used.
- req deasserted before grant: no grant, no beats.
- req for the current owner reasserted in the IDLE cycle: treated as a new request, still round-robin ordered.
- Values are passed unmodified; no arithmetic or width conversion.
- NUM_REQ=1: out_id is always 0 and rr_ptr is constant 0.

Test Plan:
1. After reset, req[2]=1 with x=100, y=2, z=1, z_sup[2]=1, out_ready=1 -> three beats 100/2/1 with field 0/1/2 and out_id=2; out_last and ack[2] high only on beat 3; busy high 3 cycles; req[2] dropped -> busy=0.
2. req[0], req[1], req[3] set together after reset and held until each ack; req[0] reasserted after its ack -> reports in order 0, 1, 3, 0; no requester served twice before the others.
3. out_ready low for 5 cycles during the Y beat of a report with y=2 -> out_data=2, out_field=1 and out_id held stable; no ack until the Z beat handshake; total report 9 cycles.
4. z_sup[1]=0, z_val=77, Z_DEFAULT=4 -> Z beat out_data=4; the X and Y beats carry the supplied values.
5. rst_n low for 1 cycle during the SEND_Y beat of requester 3 with req[0] and req[3] pending -> next cycle out_valid=0 and busy=0, no ack[3]; after reset, requester 0 is granted first, then 3.
6. x_val changed the cycle after grant -> X beat carries the pre-grant value; a req pulse of 1 cycle dropped before grant while busy -> no beats for that requester.

Source files
------------

// File: rtl/param_report_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : param_report_arbiter
//  Purpose  : Round-robin arbiter that serialises one requester's X/Y/Z
//             parameter report as three valid/ready beats on a shared channel.
//  Revision : 1.0  initial release
// ============================================================================
module param_report_arbiter #(
    parameter  int NUM_REQ   = 4,
    parameter  int VAL_W     = 32,
    parameter  int Z_DEFAULT = 4,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*VAL_W-1:0] x_val,
    input  logic [NUM_REQ*VAL_W-1:0] y_val,
    input  logic [NUM_REQ*VAL_W-1:0] z_val,
    input  logic [NUM_REQ-1:0]       z_sup,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [VAL_W-1:0]         out_data,
    output logic [1:0]               out_field,
    output logic [ID_W-1:0]          out_id,
    output logic                     out_last,
    output logic                     busy
);

    localparam logic [VAL_W-1:0] c_z_default = VAL_W'(Z_DEFAULT);
    localparam logic [ID_W-1:0]  c_last_idx  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_X = 2'd1,
        SEND_Y = 2'd2,
        SEND_Z = 2'd3
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [VAL_W-1:0]   r_y;
    logic [VAL_W-1:0]   r_z;

    logic               w_found;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_next_ptr;
    logic [VAL_W-1:0]   w_x;
    logic [VAL_W-1:0]   w_y;
    logic [VAL_W-1:0]   w_z;
    logic               w_hs;
    int                 w_dist;
    int                 w_best;

    // Winner is the set request at the smallest circular distance from rr_ptr.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_best   = 0;
        w_dist   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = i - int'(r_rr_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (req[i] && (!w_found || (w_dist < w_best))) begin
                w_found  = 1'b1;
                w_best   = w_dist;
                w_winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_x = '0;
        w_y = '0;
        w_z = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_x = x_val[i*VAL_W +: VAL_W];
                w_y = y_val[i*VAL_W +: VAL_W];
                w_z = z_sup[i] ? z_val[i*VAL_W +: VAL_W] : c_z_default;
            end
        end
    end

    assign w_next_ptr = (w_winner == c_last_idx) ? '0 : (w_winner + ID_W'(1));
    assign w_hs       = out_valid & out_ready;
    assign busy       = (r_state != IDLE);

    // X goes straight to out_data at grant; Y and Z wait in holding registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_y       <= '0;
            r_z       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_field <= 2'd0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state   <= SEND_X;
                        r_rr_ptr  <= w_next_ptr;
                        r_y       <= w_y;
                        r_z       <= w_z;
                        out_valid <= 1'b1;
                        out_data  <= w_x;
                        out_field <= 2'd0;
                        out_id    <= w_winner;
                        out_last  <= 1'b0;
                    end
                end
                SEND_X: begin
                    if (w_hs) begin
                        r_state   <= SEND_Y;
                        out_data  <= r_y;
                        out_field <= 2'd1;
                    end
                end
                SEND_Y: begin
                    if (w_hs) begin
                        r_state   <= SEND_Z;
                        out_data  <= r_z;
                        out_field <= 2'd2;
                        out_last  <= 1'b1;
                    end
                end
                SEND_Z: begin
                    if (w_hs) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_ack
            assign ack[g] = w_hs & out_last & (out_id == ID_W'(g));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_param_report_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_report_arbiter
//  Purpose  : Directed self-checking bench for param_report_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_report_arbiter;

    localparam int NUM_REQ = 4;
    localparam int VAL_W   = 32;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*VAL_W-1:0] x_val;
    logic [NUM_REQ*VAL_W-1:0] y_val;
    logic [NUM_REQ*VAL_W-1:0] z_val;
    logic [NUM_REQ-1:0]       z_sup;
    logic [NUM_REQ-1:0]       ack;
    logic                     out_valid;
    logic                     out_ready;
    logic [VAL_W-1:0]         out_data;
    logic [1:0]               out_field;
    logic [ID_W-1:0]          out_id;
    logic                     out_last;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;

    param_report_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .VAL_W     (VAL_W),
        .Z_DEFAULT (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .x_val     (x_val),
        .y_val     (y_val),
        .z_val     (z_val),
        .z_sup     (z_sup),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_field (out_field),
        .out_id    (out_id),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_vals(input int i, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] z, input logic sup);
        x_val[i*VAL_W +: VAL_W] = x;
        y_val[i*VAL_W +: VAL_W] = y;
        z_val[i*VAL_W +: VAL_W] = z;
        z_sup[i]                = sup;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] data, input int field,
                            input int id, input logic last);
        logic [31:0] exp_ack;
        exp_ack = last ? (32'd1 << id) : 32'd0;
        check_val({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_val({tag, ".data"},  out_data, data);
        check_val({tag, ".field"}, 32'(out_field), 32'(field));
        check_val({tag, ".id"},    32'(out_id), 32'(id));
        check_val({tag, ".last"},  32'(out_last), 32'(last));
        check_val({tag, ".ack"},   32'(ack), exp_ack);
        check_val({tag, ".busy"},  32'(busy), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        check_val({tag, ".valid"}, 32'(out_valid), 32'd0);
        check_val({tag, ".busy"},  32'(busy), 32'd0);
        check_val({tag, ".ack"},   32'(ack), 32'd0);
    endtask

    // Entered at the negedge showing the X beat; returns one cycle after the
    // IDLE cycle, i.e. showing the next grant if one was pending.
    task automatic serve(input string tag, input int id, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] z);
        chk_beat({tag, ".X"}, x, 0, id, 1'b0);
        step();
        chk_beat({tag, ".Y"}, y, 1, id, 1'b0);
        step();
        chk_beat({tag, ".Z"}, z, 2, id, 1'b1);
        req[id] = 1'b0;
        step();
        chk_idle({tag, ".idle"});
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        x_val     = '0;
        y_val     = '0;
        z_val     = '0;
        z_sup     = '1;
        out_ready = 1'b1;
        @(negedge clk);
        step();
        step();
        chk_idle("reset");
        check_val("reset.data",  out_data, 32'd0);
        check_val("reset.field", 32'(out_field), 32'd0);
        check_val("reset.id",    32'(out_id), 32'd0);
        check_val("reset.last",  32'(out_last), 32'd0);
        rst_n = 1'b1;
        step();
        chk_idle("reset.norq");

        // single report from requester 2
        set_vals(2, 32'd100, 32'd2, 32'd1, 1'b1);
        req[2] = 1'b1;
        step();
        serve("t1", 2, 32'd100, 32'd2, 32'd1);
        chk_idle("t1.after");

        // round robin 0,1,3 then 0 again
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_vals(i, 32'(10 + i), 32'(20 + i), 32'(30 + i), 1'b1);
        end
        req = 4'b1011;
        step();
        serve("t2.r0", 0, 32'd10, 32'd20, 32'd30);
        req[0] = 1'b1;
        serve("t2.r1", 1, 32'd11, 32'd21, 32'd31);
        serve("t2.r3", 3, 32'd13, 32'd23, 32'd33);
        serve("t2.r0b", 0, 32'd10, 32'd20, 32'd30);
        chk_idle("t2.done");

        // backpressure on the Y beat: 1 IDLE + X + 6 Y + Z = 9 cycles
        set_vals(1, 32'd7, 32'd2, 32'd9, 1'b1);
        req[1] = 1'b1;
        step();
        chk_beat("t3.X", 32'd7, 0, 1, 1'b0);
        step();
        chk_beat("t3.Y0", 32'd2, 1, 1, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_beat($sformatf("t3.Ystall%0d", k), 32'd2, 1, 1, 1'b0);
        end
        out_ready = 1'b1;
        check_val("t3.Yready.ack", 32'(ack), 32'd0);
        step();
        chk_beat("t3.Z", 32'd9, 2, 1, 1'b1);
        req[1] = 1'b0;
        step();
        chk_idle("t3.idle");
        step();

        // Z not supplied -> default value 4
        set_vals(1, 32'd5, 32'd6, 32'd77, 1'b0);
        req[1] = 1'b1;
        step();
        serve("t4", 1, 32'd5, 32'd6, 32'd4);
        z_sup[1] = 1'b1;

        // reset during SEND_Y of requester 3 with 0 pending
        set_vals(0, 32'd40, 32'd41, 32'd42, 1'b1);
        set_vals(3, 32'd50, 32'd51, 32'd52, 1'b1);
        req = 4'b1000;
        step();
        chk_beat("t5.X", 32'd50, 0, 3, 1'b0);
        req[0] = 1'b1;
        step();
        chk_beat("t5.Y", 32'd51, 1, 3, 1'b0);
        rst_n = 1'b0;
        step();
        chk_idle("t5.rst");
        check_val("t5.rst.id", 32'(out_id), 32'd0);
        rst_n = 1'b1;
        step();
        serve("t5.r0", 0, 32'd40, 32'd41, 32'd42);
        serve("t5.r3", 3, 32'd50, 32'd51, 32'd52);

        // reset during requester 1 with 0 and 2 pending: pointer must restart at 0
        set_vals(1, 32'd60, 32'd61, 32'd62, 1'b1);
        set_vals(2, 32'd70, 32'd71, 32'd72, 1'b1);
        req = 4'b0010;
        step();
        chk_beat("t5b.X", 32'd60, 0, 1, 1'b0);
        req = 4'b0111;
        rst_n = 1'b0;
        step();
        chk_idle("t5b.rst");
        rst_n = 1'b1;
        step();
        serve("t5b.r0", 0, 32'd40, 32'd41, 32'd42);
        serve("t5b.r1", 1, 32'd60, 32'd61, 32'd62);
        serve("t5b.r2", 2, 32'd70, 32'd71, 32'd72);

        // inputs change after grant; short req pulse while busy is ignored
        set_vals(2, 32'd100, 32'd2, 32'd1, 1'b1);
        req[2] = 1'b1;
        step();
        set_vals(2, 32'd555, 32'd666, 32'd777, 1'b1);
        req[1] = 1'b1;
        chk_beat("t6.X", 32'd100, 0, 2, 1'b0);
        step();
        req[1] = 1'b0;
        chk_beat("t6.Y", 32'd2, 1, 2, 1'b0);
        step();
        chk_beat("t6.Z", 32'd1, 2, 2, 1'b1);
        req[2] = 1'b0;
        step();
        chk_idle("t6.idle");
        for (int k = 0; k < 3; k++) begin
            step();
            chk_idle($sformatf("t6.quiet%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
